// File: rtl/picorv32_mem_pkg.sv
// Shared constants for the picorv32 native-interface memory slave:
// FSM state encoding, default MMIO map values and wait counter width.
package picorv32_mem_pkg;

  localparam int WAIT_CNT_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_TEST_ADDR    = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;
  localparam logic [31:0] DEF_ERR_RDATA    = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_sram_bank.sv
// Word-organised SRAM with byte-lane writes. The word index is captured
// when a request is accepted; reads are combinational from that index so
// a write cycle still presents the old word contents.
module mem_sram_bank #(
  parameter int MEM_WORDS = 32768,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          addr_load,
  input  logic [AW-1:0] addr_in,
  input  logic [3:0]    byte_we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0]   sram [MEM_WORDS];
  logic [AW-1:0] addr_q;

  // Capture the word index of the accepted request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_q <= '0;
    end else if (addr_load) begin
      addr_q <= addr_in;
    end
  end

  // Byte-lane writes into the array; contents are never reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) begin
        sram[addr_q][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = sram[addr_q];

endmodule

// File: rtl/picorv32_mem_slave.sv
// Native-interface memory slave for the picorv32 core: SRAM, programmable
// wait states, a console register and a sticky test-result register.
module picorv32_mem_slave
  import picorv32_mem_pkg::*;
#(
  parameter int          MEM_WORDS    = 32768,
  parameter int          LATENCY      = 0,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] TEST_ADDR    = DEF_TEST_ADDR,
  parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC,
  parameter logic [31:0] ERR_RDATA    = DEF_ERR_RDATA
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  output logic        tests_passed,
  output logic        tests_failed,
  output logic        bus_error
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [1:0]            state;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [31:2]           addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [31:0]           rdata_hold;
  logic [31:0]           resp_data;
  logic [31:0]           sram_rdata;
  logic [3:0]            byte_we;
  logic                  in_resp;
  logic                  is_write;
  logic                  sel_sram;
  logic                  sel_console;
  logic                  sel_test;
  logic                  accept;
  logic                  unused_addr_bits;

  // Byte offset bits carry no meaning on this word-only bus.
  assign unused_addr_bits = ^mem_addr[1:0];

  assign accept      = (state == ST_IDLE) && mem_valid;
  assign in_resp     = (state == ST_RESP);
  assign is_write    = |wstrb_q;
  assign sel_sram    = ({2'b00, addr_q} < 32'(MEM_WORDS));
  assign sel_console = (addr_q == CONSOLE_ADDR[31:2]);
  assign sel_test    = (addr_q == TEST_ADDR[31:2]);

  // Request FSM: accept in IDLE, count wait states, respond for one cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr[31:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            if (LATENCY > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_CNT_W'(LATENCY - 1);
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response data selected by the decoded target of the latched address.
  always_comb begin
    resp_data = ERR_RDATA;
    if (sel_sram) begin
      resp_data = sram_rdata;
    end else if (sel_console) begin
      resp_data = 32'h0;
    end else if (sel_test) begin
      resp_data = {30'b0, tests_failed, tests_passed};
    end
  end

  // Sticky flags and read-data hold register, committed in the RESP cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tests_passed <= 1'b0;
      tests_failed <= 1'b0;
      bus_error    <= 1'b0;
      rdata_hold   <= '0;
    end else if (in_resp) begin
      rdata_hold <= resp_data;
      if (!sel_sram && !sel_console && !sel_test) begin
        bus_error <= 1'b1;
      end
      if (sel_test && is_write) begin
        if (wdata_q == PASS_MAGIC) begin
          tests_passed <= 1'b1;
        end else begin
          tests_failed <= 1'b1;
        end
      end
    end
  end

  assign mem_ready     = in_resp;
  assign mem_rdata     = in_resp ? resp_data : rdata_hold;
  assign console_valid = in_resp && sel_console && is_write;
  assign console_data  = console_valid ? wdata_q[7:0] : 8'h00;
  assign byte_we       = (in_resp && sel_sram) ? wstrb_q : 4'b0000;

  mem_sram_bank #(
    .MEM_WORDS(MEM_WORDS)
  ) sram_bank (
    .clock    (clock),
    .resetn   (resetn),
    .addr_load(accept),
    .addr_in  (mem_addr[AW+1:2]),
    .byte_we  (byte_we),
    .wdata    (wdata_q),
    .rdata    (sram_rdata)
  );

endmodule

// File: tb/tb_picorv32_mem_slave.sv
// Directed bench for picorv32_mem_slave: three instances with LATENCY 0, 3
// and 5 share one clock and reset; a vector table drives single accesses,
// hand sequences cover back-to-back, ignored bus changes and mid-wait reset.
module tb_picorv32_mem_slave;

  localparam logic [31:0] CON  = 32'h1000_0000;
  localparam logic [31:0] TST  = 32'h2000_0000;
  localparam logic [31:0] PASS = 32'd123456789;

  logic        clock;
  logic        resetn;
  logic        valid         [3];
  logic [31:0] addr          [3];
  logic [31:0] wdata         [3];
  logic [3:0]  wstrb         [3];
  logic        ready         [3];
  logic [31:0] rdata         [3];
  logic        console_valid [3];
  logic [7:0]  console_data  [3];
  logic        passed        [3];
  logic        failed        [3];
  logic        berr          [3];

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    string       name;
    int          dut;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chkRdata;
    logic [31:0] expRdata;
    int          expLat;
    logic        expCv;
    logic [7:0]  expCd;
    logic [2:0]  expFlags;
  } vec_t;

  vec_t vecs[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  picorv32_mem_slave #(.LATENCY(0)) u_lat0 (
    .clock(clock), .resetn(resetn), .mem_valid(valid[0]), .mem_ready(ready[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rdata(rdata[0]),
    .console_valid(console_valid[0]), .console_data(console_data[0]),
    .tests_passed(passed[0]), .tests_failed(failed[0]), .bus_error(berr[0])
  );

  picorv32_mem_slave #(.LATENCY(3)) u_lat3 (
    .clock(clock), .resetn(resetn), .mem_valid(valid[1]), .mem_ready(ready[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rdata(rdata[1]),
    .console_valid(console_valid[1]), .console_data(console_data[1]),
    .tests_passed(passed[1]), .tests_failed(failed[1]), .bus_error(berr[1])
  );

  picorv32_mem_slave #(.LATENCY(5)) u_lat5 (
    .clock(clock), .resetn(resetn), .mem_valid(valid[2]), .mem_ready(ready[2]),
    .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]), .mem_rdata(rdata[2]),
    .console_valid(console_valid[2]), .console_data(console_data[2]),
    .tests_passed(passed[2]), .tests_failed(failed[2]), .bus_error(berr[2])
  );

  function automatic logic [2:0] getFlags(input int d);
    return {berr[d], failed[d], passed[d]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic chk, input logic [31:0] er, input int lat,
                        input logic cv, input logic [7:0] cd, input logic [2:0] fl);
    vec_t v;
    v.name = name; v.dut = d; v.addr = a; v.wdata = wd; v.wstrb = ws;
    v.chkRdata = chk; v.expRdata = er; v.expLat = lat; v.expCv = cv; v.expCd = cd; v.expFlags = fl;
    vecs.push_back(v);
  endtask

  // One complete access on instance d; returns the data and strobes seen in
  // the ready cycle, the latency in cycles (0 = timed out) and whether the
  // ready pulse dropped again on the following cycle.
  task automatic applyStimulus(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                               output logic [31:0] rd, output int lat, output logic cv,
                               output logic [7:0] cd, output logic pulseOk);
    @(negedge clock);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    @(posedge clock);
    #1 valid[d] = 1'b0;
    lat = 0; rd = '0; cv = 1'b0; cd = '0; pulseOk = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (ready[d] === 1'b1) begin
        lat = i; rd = rdata[d]; cv = console_valid[d]; cd = console_data[d];
        break;
      end
    end
    @(negedge clock);
    pulseOk = (ready[d] === 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        cv;
    logic [7:0]  cd;
    logic        pulseOk;
    logic        sawReady;

    resetn = 1'b0;
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end

    u_lat0.sram_bank.sram[4] = 32'hCAFE_F00D;
    u_lat0.sram_bank.sram[5] = 32'h0000_0000;
    u_lat3.sram_bank.sram[4] = 32'h0000_0000;
    u_lat3.sram_bank.sram[8] = 32'hAABB_CCDD;
    u_lat5.sram_bank.sram[2] = 32'h5A5A_5A5A;

    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset_ready%0d", d), 32'(ready[d]), 32'd0);
      checkOutput($sformatf("reset_rdata%0d", d), rdata[d], 32'd0);
      checkOutput($sformatf("reset_cvalid%0d", d), 32'(console_valid[d]), 32'd0);
      checkOutput($sformatf("reset_cdata%0d", d), 32'(console_data[d]), 32'd0);
      checkOutput($sformatf("reset_flags%0d", d), 32'(getFlags(d)), 32'd0);
    end
    resetn = 1'b1;
    @(negedge clock);

    //     name             dut addr          wdata          wstrb    chk  expRdata      lat cv   cd     flags
    addVec("rd_sram_l0",    0, 32'h10,       32'h0,         4'b0000, 1, 32'hCAFEF00D, 1, 1'b0, 8'h00, 3'b000);
    addVec("wr_lanes_l3",   1, 32'h20,       32'h11223344,  4'b0101, 1, 32'hAABBCCDD, 4, 1'b0, 8'h00, 3'b000);
    addVec("rd_lanes_l3",   1, 32'h20,       32'h0,         4'b0000, 1, 32'hAA22CC44, 4, 1'b0, 8'h00, 3'b000);
    addVec("con_A",         0, CON,          32'h41,        4'b0001, 1, 32'h0,        1, 1'b1, 8'h41, 3'b000);
    addVec("con_LF",        0, CON,          32'h0A,        4'b0001, 1, 32'h0,        1, 1'b1, 8'h0A, 3'b000);
    addVec("con_rd",        0, CON,          32'h0,         4'b0000, 1, 32'h0,        1, 1'b0, 8'h00, 3'b000);
    addVec("test_pass",     0, TST,          PASS,          4'b1111, 0, 32'h0,        1, 1'b0, 8'h00, 3'b001);
    addVec("test_rd1",      0, TST,          32'h0,         4'b0000, 1, 32'h1,        1, 1'b0, 8'h00, 3'b001);
    addVec("test_fail",     0, TST,          32'h5,         4'b1111, 0, 32'h0,        1, 1'b0, 8'h00, 3'b011);
    addVec("test_rd3",      0, TST,          32'h0,         4'b0000, 1, 32'h3,        1, 1'b0, 8'h00, 3'b011);
    addVec("unmapped_rd",   0, 32'h30000000, 32'h0,         4'b0000, 1, 32'hDEADBEEF, 1, 1'b0, 8'h00, 3'b111);
    addVec("sram_after_be", 0, 32'h10,       32'h0,         4'b0000, 1, 32'hCAFEF00D, 1, 1'b0, 8'h00, 3'b111);
    addVec("wr_full_old",   0, 32'h14,       32'h12345678,  4'b1111, 1, 32'h0,        1, 1'b0, 8'h00, 3'b111);
    addVec("rd_unaligned",  0, 32'h17,       32'h0,         4'b0000, 1, 32'h12345678, 1, 1'b0, 8'h00, 3'b111);
    addVec("unmapped_wr",   0, 32'h30000004, 32'hFFFFFFFF,  4'b1111, 1, 32'hDEADBEEF, 1, 1'b0, 8'h00, 3'b111);
    addVec("con_l3",        1, CON,          32'h155,       4'b0001, 1, 32'h0,        4, 1'b1, 8'h55, 3'b000);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].dut, vecs[k].addr, vecs[k].wdata, vecs[k].wstrb, rd, lat, cv, cd, pulseOk);
      checkOutput({vecs[k].name, "_lat"}, 32'(lat), 32'(vecs[k].expLat));
      checkOutput({vecs[k].name, "_pulse"}, 32'(pulseOk), 32'd1);
      checkOutput({vecs[k].name, "_cvalid"}, 32'(cv), 32'(vecs[k].expCv));
      if (vecs[k].expCv) checkOutput({vecs[k].name, "_cdata"}, 32'(cd), 32'(vecs[k].expCd));
      if (vecs[k].chkRdata) checkOutput({vecs[k].name, "_rdata"}, rd, vecs[k].expRdata);
      checkOutput({vecs[k].name, "_flags"}, 32'(getFlags(vecs[k].dut)), 32'(vecs[k].expFlags));
    end

    // Back-to-back: valid held high across RESP is accepted again next cycle.
    @(negedge clock);
    valid[0] = 1'b1; addr[0] = 32'h10; wstrb[0] = 4'b0000;
    @(negedge clock);
    checkOutput("b2b_ready1", 32'(ready[0]), 32'd1);
    checkOutput("b2b_rdata1", rdata[0], 32'hCAFEF00D);
    @(negedge clock);
    checkOutput("b2b_gap", 32'(ready[0]), 32'd0);
    checkOutput("b2b_hold", rdata[0], 32'hCAFEF00D);
    @(negedge clock);
    checkOutput("b2b_ready2", 32'(ready[0]), 32'd1);
    valid[0] = 1'b0;
    @(negedge clock);
    checkOutput("b2b_idle", 32'(ready[0]), 32'd0);

    // Bus changes during WAIT must not disturb the latched read.
    @(negedge clock);
    valid[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h0; wstrb[1] = 4'b0000;
    @(posedge clock);
    #1 addr[1] = 32'h10; wdata[1] = 32'hFFFF_FFFF; wstrb[1] = 4'b1111;
    @(negedge clock);
    valid[1] = 1'b0;
    lat = 0; rd = '0;
    for (int i = 2; i <= 40; i++) begin
      @(negedge clock);
      if (ready[1] === 1'b1) begin
        lat = i; rd = rdata[1];
        break;
      end
    end
    checkOutput("ignore_lat", 32'(lat), 32'd4);
    checkOutput("ignore_rdata", rd, 32'hAA22CC44);
    applyStimulus(1, 32'h10, 32'h0, 4'b0000, rd, lat, cv, cd, pulseOk);
    checkOutput("ignore_no_write", rd, 32'h0);

    // Reset asserted while the LATENCY=5 instance is waiting.
    @(negedge clock);
    valid[2] = 1'b1; addr[2] = 32'h08; wdata[2] = 32'h0; wstrb[2] = 4'b1111;
    @(posedge clock);
    #1 valid[2] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b0;
    sawReady = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (ready[2] !== 1'b0) sawReady = 1'b1;
    end
    checkOutput("rst_no_ready", 32'(sawReady), 32'd0);
    checkOutput("rst_rdata", rdata[2], 32'd0);
    checkOutput("rst_flags0", 32'(getFlags(0)), 32'd0);
    checkOutput("rst_flags2", 32'(getFlags(2)), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    applyStimulus(2, 32'h08, 32'h0, 4'b0000, rd, lat, cv, cd, pulseOk);
    checkOutput("post_rst_lat", 32'(lat), 32'd6);
    checkOutput("post_rst_rdata", rd, 32'h5A5A5A5A);
    checkOutput("post_rst_pulse", 32'(pulseOk), 32'd1);
    checkOutput("post_rst_flags", 32'(getFlags(2)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
